// File: rtl/systolic_feeder.sv
// Feed stage for the NxN systolic array: offsets A, skews A/B diagonally, clears and flushes.
// Define FEEDER_OFFSET_EN to add the latched input_offset to every A lane.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int KW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic [8:0]      input_offset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*N-1:0]  a_data,
    input  logic [8*N-1:0]  b_data,
    output logic [9*N-1:0]  left_o,
    output logic [8*N-1:0]  top_o,
    output logic            pe_rst_o,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_t;

    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

    state_t        state;
    logic [KW-1:0] k_q;
    logic [KW-1:0] cnt;
    logic [FW-1:0] fcnt;
    logic          accept;

    assign accept = in_ready & in_valid;

`ifdef FEEDER_OFFSET_EN
    logic [8:0] offset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q <= '0;
        end else if (state == IDLE && start) begin
            offset_q <= input_offset;
        end
    end
`else
    logic unused_offset;
    assign unused_offset = ^input_offset;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k_q      <= '0;
            cnt      <= '0;
            fcnt     <= '0;
            in_ready <= 1'b0;
            pe_rst_o <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_q      <= k_len;
                        state    <= CLEAR;
                        pe_rst_o <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    pe_rst_o <= 1'b0;
                    cnt      <= '0;
                    fcnt     <= '0;
                    if (k_q == '0) begin
                        state <= FLUSH;
                    end else begin
                        state    <= FEED;
                        in_ready <= 1'b1;
                    end
                end
                FEED: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == k_q) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == FLUSH_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane i is an (i+1)-deep shift register whose last stage is the output.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [8:0] a_ext;
        logic [8:0] inj_l;
        logic [7:0] inj_t;
        logic [8:0] ld [0:i];
        logic [7:0] td [0:i];

        assign a_ext = {a_data[8*i+7], a_data[8*i +: 8]};
`ifdef FEEDER_OFFSET_EN
        assign inj_l = accept ? a_ext + offset_q : '0;
`else
        assign inj_l = accept ? a_ext : '0;
`endif
        assign inj_t = accept ? b_data[8*i +: 8] : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= i; j++) begin
                    ld[j] <= '0;
                    td[j] <= '0;
                end
            end else begin
                ld[0] <= inj_l;
                td[0] <= inj_t;
                for (int j = 1; j <= i; j++) begin
                    ld[j] <= ld[j-1];
                    td[j] <= td[j-1];
                end
            end
        end

        assign left_o[9*i +: 9] = ld[i];
        assign top_o[8*i +: 8]  = td[i];
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream feed stage for the N×N weight-stationary-free systolic PE array. It accepts one K-step beat per handshake, holding an N-lane A column (int8) and an N-lane B row (int8). It applies the input offset to A, producing 9-bit signed values, and diagonally skews both operands so that lane i is delayed i cycles. It drives the array's left and top edges, issues the one-cycle PE accumulator clear, and flushes zeros until every PE accumulator holds its final value.

## Interface
- N, 4, array dimension (lanes per edge)
- KW, 16, width of K-length counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request; accepted only in IDLE
- k_len  in  KW  beats to feed; latched on accepted start
- input_offset  in  9  signed offset added to A; latched on accepted start
- in_valid  in  1  beat valid (A and B travel together)
- in_ready  out  1  beat accepted when in_valid&in_ready
- a_data  in  8N  lane i = bits [8i+7:8i], signed int8
- b_data  in  8N  lane i = bits [8i+7:8i], signed int8
- left_o  out  9N  lane i drives row i left_i
- top_o  out  8N  lane i drives column i top_i
- pe_rst_o  out  1  accumulator clear to all PEs
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; all PE accs final while high

## Operation
- States: IDLE → CLEAR → FEED → FLUSH → DONE → IDLE.
- IDLE: start=1 latches k_len and offset, then goes to CLEAR. start in any other state is ignored.
- CLEAR: pe_rst_o=1 for exactly one cycle. Next state is FEED, or FLUSH if the latched k_len==0.
- FEED: in_ready=1. Each accepted beat increments the beat counter. When the last (k_len-th) beat is accepted, the next state is FLUSH.
- Bubbles in FEED: a cycle without in_valid injects zeros into both left and top lanes. The wavefront stays aligned and the accumulators are unaffected.
- FLUSH: exactly 2N-1 cycles, in_ready=0, zeros injected. Then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Left value per accepted beat: sign-extend a lane to 9 bits, add the latched input_offset, keep the low 9 bits (mod 2^9, no saturation).
- Injected zero on left is 0, never the offset.
- Skew: each lane is a delay line that shifts every cycle in all states.
  - The value injected in cycle t appears on lane i of left_o/top_o during cycle t+1+i.
  - Output registers are included, so lane 0 has 1-cycle latency and lane N-1 has N-cycle latency.
- in_ready is 0 outside FEED. pe_rst_o is 0 outside CLEAR.

## Timing
- Reset values: all delay-line registers 0, left_o=0, top_o=0, pe_rst_o=0, in_ready=0, busy=0, done=0, state IDLE, counters 0.
- Reset mid-operation returns to IDLE in the next cycle and zeroes every delay line. No done is issued.
- start accepted in cycle s:
  - CLEAR occupies s+1, with pe_rst_o high.
  - FEED begins at s+2, with in_ready high.
- Last beat accepted in cycle T:
  - FLUSH occupies T+1..T+2N-1.
  - done is high in T+2N.
  - PE(r,c) sees the last beat's product on the edge ending cycle T+1+r+c. The worst case is T+2N-1, so all accs are final during done.
- No back-to-back overlap: the earliest next start is accepted in the IDLE cycle following done.
- Minimum job length with k_len=K and no bubbles is 1+K+(2N-1)+1 cycles after the start cycle.

## Configuration
- FEEDER_OFFSET_EN defined: left value = sext(a)+input_offset, as above.
- FEEDER_OFFSET_EN undefined:
  - left value = sext(a) only.
  - The input_offset port remains but is ignored, and the offset register is not built.

## Test plan
- Single beat, N=4, offset=128 (with _EN), a=all -128, b=all 5, k_len=1:
  - left_o lane i = 0, appearing at cycle T+1+i.
  - done at T+8.
  - With _EN undefined, lane i = -128 (0x180).
- k_len=3, a lanes {1,2,3,4} each beat, b lanes {1,1,1,1}, offset=0, driving a PE-array model → every acc in row r = 3·(r+1) when done is high.
- Bubbles: k_len=2 with in_valid low for 3 cycles between beats → zeros injected, accs equal the no-bubble result, done 3 cycles later.
- Offset wrap: a=127, offset=200 → left lane = 327 mod 512 = 0x147 (treated as signed -185).
- k_len=0 → CLEAR, then FLUSH of 7 cycles, then done; in_ready never asserts; accs=0.
- Assert reset during FEED after 2 beats → next cycle all outputs 0, IDLE, no done. A new start then runs correctly. A start issued while busy is ignored.
